// File: rtl/evm_ballot_controller.sv
// Ballot-issue controller for an electronic voting machine.
// One ballot is armed per BALLOT_EN. The first single-button press casts
// exactly one one-hot vote strobe, followed by a busy beep. The FSM then
// waits for every button to be released before it can arm again.
module evm_ballot_controller #(
   parameter int TIMEOUT_CYCLES = 1000,
   parameter int BEEP_CYCLES    = 4
) (
   input  logic       CLK,
   input  logic       CLEAR,
   input  logic       BALLOT_EN,
   input  logic       CLOSE_POLL,
   input  logic       P1,
   input  logic       P2,
   input  logic       P3,
   input  logic       P4,
   input  logic       P5,
   input  logic       NOTA,
   output logic [5:0] VOTE_STROBE,
   output logic       READY,
   output logic       BUSY,
   output logic       TIMEOUT,
   output logic       POLL_CLOSED,
   output logic       FULL,
   output logic [9:0] BALLOT_COUNT
);

   // Counter widths are sized to hold terminal values of (N-1), with a minimum of 1 bit.
   localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam int BW = (BEEP_CYCLES > 1) ? $clog2(BEEP_CYCLES) : 1;
   localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);
   localparam logic [BW-1:0] BEEP_LAST  = BW'(BEEP_CYCLES - 1);

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      ARMED    = 3'd1,
      CAST     = 3'd2,
      BEEP     = 3'd3,
      WAIT_REL = 3'd4,
      CLOSED   = 3'd5
   } state_t;

   state_t        state_q, state_d;
   logic [TW-1:0] timer_q, timer_d;
   logic [BW-1:0] beep_q, beep_d;
   logic [5:0]    strobe_q, strobe_d;
   logic          timeout_q, timeout_d;
   logic [9:0]    count_q, count_d;
   logic          full_q, full_d;

   logic [5:0]    buttons;
   logic          any_press;
   logic          valid_press;

   assign buttons     = {NOTA, P5, P4, P3, P2, P1};
   assign any_press   = |buttons;
   assign valid_press = $onehot(buttons);

   // All state, including the registered strobe/timeout/count, updates here; CLEAR wins over everything.
   always_ff @(posedge CLK) begin
      if (CLEAR) begin
         state_q   <= IDLE;
         timer_q   <= '0;
         beep_q    <= '0;
         strobe_q  <= '0;
         timeout_q <= 1'b0;
         count_q   <= '0;
         full_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         timer_q   <= timer_d;
         beep_q    <= beep_d;
         strobe_q  <= strobe_d;
         timeout_q <= timeout_d;
         count_q   <= count_d;
         full_q    <= full_d;
      end
   end

   // Next-state logic. The strobe and count are produced on the edge that enters CAST,
   // so the strobe is visible during the CAST cycle itself.
   always_comb begin
      state_d   = state_q;
      timer_d   = timer_q;
      beep_d    = beep_q;
      strobe_d  = '0;
      timeout_d = 1'b0;
      count_d   = count_q;

      case (state_q)
         IDLE: begin
            if (CLOSE_POLL) begin
               state_d = CLOSED;
            end else if (BALLOT_EN && !any_press && !full_q) begin
               state_d = ARMED;
               timer_d = '0;
            end
         end
         ARMED: begin
            timer_d = timer_q + TW'(1);
            if (valid_press) begin
               // Arming is blocked while full, so the count cannot wrap here.
               state_d  = CAST;
               strobe_d = buttons;
               count_d  = count_q + 10'd1;
            end else if (timer_q == TIMER_LAST) begin
               state_d   = IDLE;
               timeout_d = 1'b1;
               timer_d   = '0;
            end
         end
         CAST: begin
            state_d = BEEP;
            beep_d  = '0;
         end
         BEEP: begin
            if (beep_q == BEEP_LAST) begin
               state_d = WAIT_REL;
            end else begin
               beep_d = beep_q + BW'(1);
            end
         end
         WAIT_REL: begin
            if (!any_press) begin
               state_d = IDLE;
            end
         end
         CLOSED: begin
            state_d = CLOSED;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Capacity flag is registered alongside the count so it never glitches.
   always_comb begin
      full_d = (count_d == 10'h3FF);
   end

   assign VOTE_STROBE  = strobe_q;
   assign TIMEOUT      = timeout_q;
   assign BALLOT_COUNT = count_q;
   assign FULL         = full_q;
   assign READY        = (state_q == ARMED);
   assign BUSY         = (state_q == BEEP);
   assign POLL_CLOSED  = (state_q == CLOSED);

endmodule

// File: tb/tb_evm_ballot_controller.sv
// Directed bench for evm_ballot_controller: a per-cycle vector table for the
// main voting flow, plus hand-written sequences for press-vs-timeout,
// CLEAR during a vote, and capacity exhaustion.
module tb_evm_ballot_controller;

   logic       CLK = 1'b0;
   logic       CLEAR, BALLOT_EN, CLOSE_POLL;
   logic       P1, P2, P3, P4, P5, NOTA;
   logic [5:0] VOTE_STROBE;
   logic       READY, BUSY, TIMEOUT, POLL_CLOSED, FULL;
   logic [9:0] BALLOT_COUNT;

   int checks   = 0;
   int failures = 0;

   evm_ballot_controller #(
      .TIMEOUT_CYCLES(8),
      .BEEP_CYCLES   (4)
   ) dut (
      .CLK         (CLK),
      .CLEAR       (CLEAR),
      .BALLOT_EN   (BALLOT_EN),
      .CLOSE_POLL  (CLOSE_POLL),
      .P1          (P1),
      .P2          (P2),
      .P3          (P3),
      .P4          (P4),
      .P5          (P5),
      .NOTA        (NOTA),
      .VOTE_STROBE (VOTE_STROBE),
      .READY       (READY),
      .BUSY        (BUSY),
      .TIMEOUT     (TIMEOUT),
      .POLL_CLOSED (POLL_CLOSED),
      .FULL        (FULL),
      .BALLOT_COUNT(BALLOT_COUNT)
   );

   always #5 CLK = ~CLK;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   typedef struct {
      logic       en;
      logic       cls;
      logic [5:0] btn;
      logic [5:0] strobe;
      logic       ready;
      logic       busy;
      logic       tmo;
      logic       closed;
      logic [9:0] cnt;
   } vec_t;

   vec_t tbl[$];

   task automatic add(input logic en, input logic cls, input logic [5:0] btn,
                      input logic [5:0] strobe, input logic ready, input logic busy,
                      input logic tmo, input logic closed, input logic [9:0] cnt);
      vec_t v;
      v.en = en; v.cls = cls; v.btn = btn; v.strobe = strobe; v.ready = ready;
      v.busy = busy; v.tmo = tmo; v.closed = closed; v.cnt = cnt;
      tbl.push_back(v);
   endtask

   // Drive inputs on the falling edge, then sample 1 time unit after the next rising edge.
   task automatic step(input logic clr, input logic en, input logic cls, input logic [5:0] btn);
      @(negedge CLK);
      CLEAR = clr; BALLOT_EN = en; CLOSE_POLL = cls;
      {NOTA, P5, P4, P3, P2, P1} = btn;
      @(posedge CLK);
      #1;
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s got=%0h expected=%0h", nm, act, exp);
      end
   endtask

   task automatic chk_all(input string tag, input logic [5:0] strobe, input logic ready,
                          input logic busy, input logic tmo, input logic closed,
                          input logic full, input logic [9:0] cnt);
      chk({tag, ".strobe"}, 32'(VOTE_STROBE), 32'(strobe));
      chk({tag, ".ready"},  32'(READY),       32'(ready));
      chk({tag, ".busy"},   32'(BUSY),        32'(busy));
      chk({tag, ".timeout"},32'(TIMEOUT),     32'(tmo));
      chk({tag, ".closed"}, 32'(POLL_CLOSED), 32'(closed));
      chk({tag, ".full"},   32'(FULL),        32'(full));
      chk({tag, ".count"},  32'(BALLOT_COUNT),32'(cnt));
   endtask

   initial begin
      CLEAR = 1'b1; BALLOT_EN = 1'b0; CLOSE_POLL = 1'b0;
      {NOTA, P5, P4, P3, P2, P1} = 6'b0;

      // ---- Vector table: normal vote, double press, timeout, close poll ----
      // P3 vote held 10 cycles (one strobe, 4 busy cycles, idle only after release)
      add(1, 0, 6'h00, 6'h00, 1, 0, 0, 0, 1'd0);
      add(0, 0, 6'h04, 6'h04, 0, 0, 0, 0, 10'd1);
      for (int i = 0; i < 4; i++) add(0, 0, 6'h04, 6'h00, 0, 1, 0, 0, 10'd1);
      for (int i = 0; i < 4; i++) add(0, 0, 6'h04, 6'h00, 0, 0, 0, 0, 10'd1);
      add(1, 0, 6'h04, 6'h00, 0, 0, 0, 0, 10'd1);  // held: BALLOT_EN ignored
      add(0, 0, 6'h00, 6'h00, 0, 0, 0, 0, 10'd1);  // released -> IDLE
      add(1, 0, 6'h00, 6'h00, 1, 0, 0, 0, 10'd1);  // re-arm
      // P1+P2 double press ignored, then P2 alone
      for (int i = 0; i < 5; i++) add(0, 0, 6'h03, 6'h00, 1, 0, 0, 0, 10'd1);
      add(0, 0, 6'h02, 6'h02, 0, 0, 0, 0, 10'd2);
      for (int i = 0; i < 4; i++) add(0, 0, 6'h02, 6'h00, 0, 1, 0, 0, 10'd2);
      add(0, 0, 6'h00, 6'h00, 0, 0, 0, 0, 10'd2);  // WAIT_REL
      add(1, 0, 6'h00, 6'h00, 0, 0, 0, 0, 10'd2);  // -> IDLE, enable ignored
      add(1, 0, 6'h01, 6'h00, 0, 0, 0, 0, 10'd2);  // IDLE with press: ignored
      // Timeout: armed, no press, pulse 8 cycles after arming
      add(1, 0, 6'h00, 6'h00, 1, 0, 0, 0, 10'd2);
      for (int i = 0; i < 7; i++) add(0, 0, 6'h00, 6'h00, 1, 0, 0, 0, 10'd2);
      add(0, 0, 6'h00, 6'h00, 0, 0, 1, 0, 10'd2);
      add(0, 0, 6'h00, 6'h00, 0, 0, 0, 0, 10'd2);
      // CLOSE_POLL ignored while armed, NOTA vote, then close in IDLE
      add(1, 0, 6'h00, 6'h00, 1, 0, 0, 0, 10'd2);
      add(0, 1, 6'h00, 6'h00, 1, 0, 0, 0, 10'd2);
      add(0, 1, 6'h20, 6'h20, 0, 0, 0, 0, 10'd3);
      for (int i = 0; i < 4; i++) add(0, 0, 6'h00, 6'h00, 0, 1, 0, 0, 10'd3);
      add(0, 0, 6'h00, 6'h00, 0, 0, 0, 0, 10'd3);
      add(0, 0, 6'h00, 6'h00, 0, 0, 0, 0, 10'd3);
      add(1, 1, 6'h00, 6'h00, 0, 0, 0, 1, 10'd3);
      add(1, 0, 6'h00, 6'h00, 0, 0, 0, 1, 10'd3);
      add(1, 0, 6'h01, 6'h00, 0, 0, 0, 1, 10'd3);

      // Reset state
      step(1, 0, 0, 6'h00);
      step(1, 0, 0, 6'h00);
      $display("reset: strobe=%b ready=%b busy=%b cnt=%0d", VOTE_STROBE, READY, BUSY, BALLOT_COUNT);
      chk_all("reset", 6'h00, 0, 0, 0, 0, 0, 10'd0);

      foreach (tbl[i]) begin
         step(0, tbl[i].en, tbl[i].cls, tbl[i].btn);
         $display("vec %0d en=%b cls=%b btn=%b -> strobe=%b ready=%b busy=%b tmo=%b closed=%b cnt=%0d",
                  i, tbl[i].en, tbl[i].cls, tbl[i].btn, VOTE_STROBE, READY, BUSY, TIMEOUT,
                  POLL_CLOSED, BALLOT_COUNT);
         chk_all($sformatf("vec%0d", i), tbl[i].strobe, tbl[i].ready, tbl[i].busy,
                 tbl[i].tmo, tbl[i].closed, 1'b0, tbl[i].cnt);
      end

      // ---- CLEAR leaves CLOSED ----
      step(1, 0, 0, 6'h00);
      $display("clear from closed: closed=%b cnt=%0d", POLL_CLOSED, BALLOT_COUNT);
      chk_all("clr_closed", 6'h00, 0, 0, 0, 0, 0, 10'd0);

      // ---- Valid press on the timeout cycle wins ----
      step(0, 1, 0, 6'h00);
      for (int i = 0; i < 7; i++) step(0, 0, 0, 6'h00);
      chk("win.ready_before", 32'(READY), 32'd1);
      step(0, 0, 0, 6'h10);
      $display("press at timeout: strobe=%b tmo=%b cnt=%0d", VOTE_STROBE, TIMEOUT, BALLOT_COUNT);
      chk_all("win", 6'h10, 0, 0, 0, 0, 0, 10'd1);
      for (int i = 0; i < 6; i++) step(0, 0, 0, 6'h00);

      // ---- CLEAR on the edge that would enter CAST ----
      step(0, 1, 0, 6'h00);
      step(1, 0, 0, 6'h02);
      $display("clear on cast: strobe=%b cnt=%0d", VOTE_STROBE, BALLOT_COUNT);
      chk_all("clr_cast", 6'h00, 0, 0, 0, 0, 0, 10'd0);
      step(0, 1, 0, 6'h00);
      chk("clr_cast.rearm", 32'(READY), 32'd1);
      // CLEAR sampled at the end of the CAST cycle
      step(0, 0, 0, 6'h08);
      chk("cast_p4.strobe", 32'(VOTE_STROBE), 32'h08);
      step(1, 0, 0, 6'h00);
      chk_all("clr_incast", 6'h00, 0, 0, 0, 0, 0, 10'd0);
      // CLEAR mid-BEEP
      step(0, 1, 0, 6'h00);
      step(0, 0, 0, 6'h01);
      step(0, 0, 0, 6'h00);
      step(0, 0, 0, 6'h00);
      chk("beep.busy", 32'(BUSY), 32'd1);
      step(1, 0, 0, 6'h00);
      $display("clear mid-beep: busy=%b cnt=%0d", BUSY, BALLOT_COUNT);
      chk_all("clr_beep", 6'h00, 0, 0, 0, 0, 0, 10'd0);

      // ---- Capacity: 1023 votes ----
      for (int i = 0; i < 1023; i++) begin
         logic [5:0] b;
         b = 6'(1 << (i % 6));
         step(0, 1, 0, 6'h00);
         step(0, 0, 0, b);
         for (int k = 0; k < 6; k++) step(0, 0, 0, 6'h00);
         if (i == 1021) begin
            chk("cap1022.count", 32'(BALLOT_COUNT), 32'd1022);
            chk("cap1022.full", 32'(FULL), 32'd0);
         end
      end
      $display("capacity: cnt=%0d full=%b", BALLOT_COUNT, FULL);
      chk("cap.count", 32'(BALLOT_COUNT), 32'd1023);
      chk("cap.full", 32'(FULL), 32'd1);
      step(0, 1, 0, 6'h00);
      chk_all("cap_en", 6'h00, 0, 0, 0, 0, 1, 10'd1023);
      step(0, 0, 0, 6'h01);
      chk_all("cap_press", 6'h00, 0, 0, 0, 0, 1, 10'd1023);
      step(1, 0, 0, 6'h00);
      chk_all("cap_clear", 6'h00, 0, 0, 0, 0, 0, 10'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/evm_ballot_controller.md
EVM_BALLOT_CONTROLLER -- requirements
Module: evm_ballot_controller

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 1000: number of cycles an armed ballot waits for a valid press before it is cancelled.
REQ-002 Parameter BEEP_CYCLES, default 4: number of cycles BUSY is held after a vote is cast.
REQ-003 CLK  in  1  sole clock; all state changes on its rising edge.
REQ-004 CLEAR  in  1  reset, synchronous, active-high.
REQ-005 BALLOT_EN  in  1  presiding-officer "issue ballot" request.
REQ-006 CLOSE_POLL  in  1  presiding-officer "close poll" request.
REQ-007 P1, P2, P3, P4, P5, NOTA  in  1 each  voter buttons, level, already synchronised.
REQ-008 VOTE_STROBE  out  6  one-hot increment pulse to the vote-counter datapath; bit0=P1 ... bit4=P5, bit5=NOTA.
REQ-009 READY  out  1  ballot armed lamp.
REQ-010 BUSY  out  1  vote-recorded beep/lamp.
REQ-011 TIMEOUT  out  1  one-cycle pulse when an armed ballot expires.
REQ-012 POLL_CLOSED  out  1  poll closed; no further ballots.
REQ-013 FULL  out  1  ballot capacity exhausted.
REQ-014 BALLOT_COUNT  out  10  total votes cast since CLEAR.

Function
REQ-015 The FSM SHALL have exactly the states IDLE, ARMED, CAST, BEEP, WAIT_REL and CLOSED.
REQ-016 "Any press" SHALL mean any of the six buttons high; "valid press" SHALL mean exactly one button high.
REQ-017 IDLE: CLOSE_POLL=1 SHALL go to CLOSED; CLOSE_POLL has priority over BALLOT_EN.
REQ-018 IDLE: BALLOT_EN=1 with no press and FULL=0 SHALL go to ARMED and clear the timer.
REQ-019 IDLE: BALLOT_EN SHALL be ignored while any button is pressed or while FULL=1.
REQ-020 ARMED: READY=1; the timer SHALL increment every cycle.
REQ-021 ARMED: a valid press SHALL go to CAST and latch the pressed button's one-hot code.
REQ-022 ARMED: a multi-button press SHALL be ignored; the state stays ARMED and the timer keeps running.
REQ-023 ARMED: with no valid press and timer = TIMEOUT_CYCLES-1, the FSM SHALL go to IDLE with TIMEOUT=1 for that one cycle.
REQ-024 ARMED: a valid press SHALL win over a timeout occurring in the same cycle.
REQ-025 ARMED: CLOSE_POLL and BALLOT_EN SHALL be ignored.
REQ-026 CAST lasts exactly one cycle: VOTE_STROBE equals the latched code, BALLOT_COUNT increments by 1, then the FSM goes to BEEP.
REQ-027 Latency: a press sampled at edge N SHALL produce VOTE_STROBE high during cycle N+1, for exactly one cycle.
REQ-028 VOTE_STROBE SHALL be 0 in every state other than CAST; at most one vote is cast per BALLOT_EN.
REQ-029 BEEP: BUSY=1 for exactly BEEP_CYCLES cycles, then the FSM goes to WAIT_REL.
REQ-030 WAIT_REL: the FSM SHALL stay until no button is pressed, then go to IDLE; a held button SHALL never cast a second vote.
REQ-031 CLOSED: POLL_CLOSED=1 and all other inputs are ignored until CLEAR.
REQ-032 FULL SHALL be 1 whenever BALLOT_COUNT = 1023.
REQ-033 BALLOT_COUNT SHALL never wrap: the 1023rd vote sets FULL, and no further ballot can be armed.
REQ-034 READY, BUSY and POLL_CLOSED SHALL be decoded from the registered state; TIMEOUT and VOTE_STROBE SHALL be registered.
REQ-035 All outputs SHALL be glitch-free.

Reset
REQ-036 CLEAR=1 at a rising edge SHALL take priority over all inputs and apply in any state, including mid-CAST or mid-BEEP.
REQ-037 On CLEAR, the FSM SHALL go to IDLE and the timer and BEEP counter SHALL reset to 0.
REQ-038 On CLEAR, BALLOT_COUNT=0, VOTE_STROBE=6'b000000, and READY, BUSY, TIMEOUT, POLL_CLOSED and FULL SHALL all be 0.
REQ-039 A CAST cycle coinciding with CLEAR SHALL produce no strobe and no count increment.

Verification
REQ-040 BALLOT_EN pulse, then P3 held 10 cycles -> exactly one VOTE_STROBE=6'b000100 one cycle after the press; BALLOT_COUNT=1; BUSY for 4 cycles; IDLE only after P3 is released.
REQ-041 Armed, P1 and P2 pressed together for 20 cycles, then only P2 -> no strobe during the double press, then VOTE_STROBE=6'b000010 once.
REQ-042 Armed with TIMEOUT_CYCLES=8, no press -> TIMEOUT pulse 8 cycles after arming, READY=0, BALLOT_COUNT unchanged.
REQ-043 CLOSE_POLL during ARMED -> ignored; vote NOTA cast (strobe 6'b100000); CLOSE_POLL in IDLE -> POLL_CLOSED=1; later BALLOT_EN -> no READY.
REQ-044 Force 1023 votes -> FULL=1; next BALLOT_EN ignored.
REQ-045 CLEAR asserted on the CAST cycle -> VOTE_STROBE=0, BALLOT_COUNT=0, all flags 0, FSM in IDLE.
